// File: rtl/stream_priority_encoder.sv
// rtl/stream_priority_encoder.sv - registered valid/ready priority encoder, fixed or round-robin
// Optional macro SPE_ONEHOT_ERR_EN adds an err output flagging non-one-hot accepted vectors.
module stream_priority_encoder #(
    parameter int IP_WIDTH = 4,
    parameter int RR_MODE  = 0,
    localparam int OP_SIZE = $clog2(IP_WIDTH)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic [IP_WIDTH-1:0] a,
    input  logic                in_valid,
    output logic                in_ready,
    output logic [OP_SIZE-1:0]  op,
    output logic                zero,
    output logic                out_valid,
`ifdef SPE_ONEHOT_ERR_EN
    output logic                err,
`endif
    input  logic                out_ready
);

    localparam int SUM_W = OP_SIZE + 1;
    localparam logic [SUM_W-1:0] WIDTH_S = SUM_W'(IP_WIDTH);

    logic [OP_SIZE-1:0]  ptr;
    logic [OP_SIZE-1:0]  fixed_win;
    logic [OP_SIZE-1:0]  rr_off;
    logic [OP_SIZE-1:0]  rr_win;
    logic [OP_SIZE-1:0]  winner;
    logic [OP_SIZE-1:0]  ptr_next;
    logic [SUM_W-1:0]    rr_sum;
    logic [IP_WIDTH-1:0] rot;
    logic                a_zero;
    logic                accept;

    function automatic logic [OP_SIZE-1:0] lowest_set(input logic [IP_WIDTH-1:0] v);
        logic [OP_SIZE-1:0] r;
        r = '0;
        for (int i = IP_WIDTH - 1; i >= 0; i--) begin
            if (v[i]) r = OP_SIZE'(i);
        end
        return r;
    endfunction

    assign in_ready = en && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;
    assign a_zero   = (a == '0);

    assign fixed_win = lowest_set(a);

    // Rotate so the pointer position lands at bit 0, then map the offset back modulo IP_WIDTH.
    assign rot    = IP_WIDTH'({a, a} >> ptr);
    assign rr_off = lowest_set(rot);
    assign rr_sum = {1'b0, ptr} + {1'b0, rr_off};
    assign rr_win = (rr_sum >= WIDTH_S) ? OP_SIZE'(rr_sum - WIDTH_S) : OP_SIZE'(rr_sum);

    assign winner   = a_zero ? '0 : ((RR_MODE != 0) ? rr_win : fixed_win);
    assign ptr_next = (winner == OP_SIZE'(IP_WIDTH - 1)) ? '0 : winner + OP_SIZE'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            op        <= '0;
            zero      <= 1'b0;
            ptr       <= '0;
        end else if (en) begin
            if (accept) begin
                out_valid <= 1'b1;
                op        <= winner;
                zero      <= a_zero;
                if ((RR_MODE != 0) && !a_zero) ptr <= ptr_next;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

`ifdef SPE_ONEHOT_ERR_EN
    // a & (a-1) clears the lowest set bit; anything left means more than one request.
    always_ff @(posedge clk) begin
        if (rst) begin
            err <= 1'b0;
        end else if (accept) begin
            err <= ((a & (a - IP_WIDTH'(1))) != '0);
        end
    end
`endif

endmodule

// File: tb/tb_stream_priority_encoder.sv
// tb/tb_stream_priority_encoder.sv - self-checking bench for stream_priority_encoder
// Honours SPE_ONEHOT_ERR_EN when defined.
module tb_stream_priority_encoder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic       f_en, f_in_valid, f_in_ready, f_zero, f_out_valid, f_out_ready;
    logic [3:0] f_a;
    logic [1:0] f_op;
    logic       r_en, r_in_valid, r_in_ready, r_zero, r_out_valid, r_out_ready;
    logic [4:0] r_a;
    logic [2:0] r_op;
    logic       q_en, q_in_valid, q_in_ready, q_zero, q_out_valid, q_out_ready;
    logic [3:0] q_a;
    logic [1:0] q_op;
`ifdef SPE_ONEHOT_ERR_EN
    logic f_err, r_err, q_err;
`endif

    stream_priority_encoder #(.IP_WIDTH(4), .RR_MODE(0)) u_fixed (
        .clk(clk), .rst(rst), .en(f_en), .a(f_a), .in_valid(f_in_valid), .in_ready(f_in_ready),
        .op(f_op), .zero(f_zero), .out_valid(f_out_valid),
`ifdef SPE_ONEHOT_ERR_EN
        .err(f_err),
`endif
        .out_ready(f_out_ready)
    );

    stream_priority_encoder #(.IP_WIDTH(5), .RR_MODE(1)) u_rr5 (
        .clk(clk), .rst(rst), .en(r_en), .a(r_a), .in_valid(r_in_valid), .in_ready(r_in_ready),
        .op(r_op), .zero(r_zero), .out_valid(r_out_valid),
`ifdef SPE_ONEHOT_ERR_EN
        .err(r_err),
`endif
        .out_ready(r_out_ready)
    );

    stream_priority_encoder #(.IP_WIDTH(4), .RR_MODE(1)) u_rr4 (
        .clk(clk), .rst(rst), .en(q_en), .a(q_a), .in_valid(q_in_valid), .in_ready(q_in_ready),
        .op(q_op), .zero(q_zero), .out_valid(q_out_valid),
`ifdef SPE_ONEHOT_ERR_EN
        .err(q_err),
`endif
        .out_ready(q_out_ready)
    );

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    typedef struct {
        int a;
        int op;
        int zero;
    } vec_t;

    typedef struct {
        int valid;
        int op;
        int zero;
        int err;
        int ptr;
    } mdl_t;

    // Reference: scan the request bits in priority order, one cycle per call.
    function automatic mdl_t mdl_step(input mdl_t m, input int w, input int rr, input int en,
                                      input int iv, input int a, input int ordy);
        mdl_t n;
        int   win, ones, idx, found;
        n = m;
        if (en != 0) begin
            if (iv != 0 && (m.valid == 0 || ordy != 0)) begin
                win = 0; found = 0; ones = 0;
                for (int k = 0; k < w; k++) begin
                    idx = (rr != 0) ? (m.ptr + k) % w : k;
                    if (found == 0 && ((a >> idx) & 1) == 1) begin
                        win = idx;
                        found = 1;
                    end
                    ones += (a >> k) & 1;
                end
                n.valid = 1;
                n.op    = win;
                n.zero  = (a == 0) ? 1 : 0;
                n.err   = (ones > 1) ? 1 : 0;
                if (rr != 0 && a != 0) n.ptr = (win + 1) % w;
            end else if (m.valid != 0 && ordy != 0) begin
                n.valid = 0;
            end
        end
        return n;
    endfunction

    vec_t fixed_tab[6];
    vec_t rr_tab[6];
    mdl_t mf, mr;

    initial begin
        fixed_tab[0] = '{4'b0001, 0, 0};
        fixed_tab[1] = '{4'b0010, 1, 0};
        fixed_tab[2] = '{4'b0100, 2, 0};
        fixed_tab[3] = '{4'b1000, 3, 0};
        fixed_tab[4] = '{4'b1010, 1, 0};
        fixed_tab[5] = '{4'b0000, 0, 1};
        rr_tab[0]    = '{5'b10101, 0, 0};
        rr_tab[1]    = '{5'b10101, 2, 0};
        rr_tab[2]    = '{5'b10101, 4, 0};
        rr_tab[3]    = '{5'b10101, 0, 0};
        rr_tab[4]    = '{5'b00000, 0, 1};
        rr_tab[5]    = '{5'b00010, 1, 0};

        rst = 1'b1;
        f_en = 1'b1; f_in_valid = 1'b1; f_a = 4'b1000; f_out_ready = 1'b1;
        r_en = 1'b1; r_in_valid = 1'b0; r_a = '0;      r_out_ready = 1'b1;
        q_en = 1'b1; q_in_valid = 1'b0; q_a = '0;      q_out_ready = 1'b1;

        // Reset held two cycles with a pending request
        repeat (2) begin
            @(negedge clk);
            chk("rst_out_valid", int'(f_out_valid), 0);
            chk("rst_op", int'(f_op), 0);
            chk("rst_zero", int'(f_zero), 0);
        end
        rst = 1'b0;
        @(negedge clk);
        chk("first_valid", int'(f_out_valid), 1);
        chk("first_op", int'(f_op), 3);

        // Fixed priority, back-to-back
        for (int i = 0; i < 6; i++) begin
            f_a = 4'(fixed_tab[i].a);
            @(negedge clk);
            chk($sformatf("fix_valid[%0d]", i), int'(f_out_valid), 1);
            chk($sformatf("fix_op[%0d]", i), int'(f_op), fixed_tab[i].op);
            chk($sformatf("fix_zero[%0d]", i), int'(f_zero), fixed_tab[i].zero);
        end
        f_in_valid = 1'b0;

        // Round-robin wrap at IP_WIDTH=5
        r_in_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            r_a = 5'(rr_tab[i].a);
            @(negedge clk);
            chk($sformatf("rr_valid[%0d]", i), int'(r_out_valid), 1);
            chk($sformatf("rr_op[%0d]", i), int'(r_op), rr_tab[i].op);
            chk($sformatf("rr_zero[%0d]", i), int'(r_zero), rr_tab[i].zero);
        end
        r_in_valid = 1'b0;

        // Backpressure
        f_a = 4'b0100; f_in_valid = 1'b1; f_out_ready = 1'b1;
        @(negedge clk);
        chk("bp_op0", int'(f_op), 2);
        f_out_ready = 1'b0; f_a = 4'b0001;
        repeat (3) begin
            #1 chk("bp_in_ready", int'(f_in_ready), 0);
            @(negedge clk);
            chk("bp_valid", int'(f_out_valid), 1);
            chk("bp_op", int'(f_op), 2);
        end
        f_out_ready = 1'b1;
        #1 chk("bp_release_ready", int'(f_in_ready), 1);
        @(negedge clk);
        chk("bp_next_valid", int'(f_out_valid), 1);
        chk("bp_next_op", int'(f_op), 0);

        // Enable freeze, drain, then reset mid-flight
        f_a = 4'b0100;
        @(negedge clk);
        chk("en_op", int'(f_op), 2);
        f_in_valid = 1'b0; f_en = 1'b0;
        #1 chk("en_in_ready", int'(f_in_ready), 0);
        repeat (2) begin
            @(negedge clk);
            chk("en_hold_valid", int'(f_out_valid), 1);
            chk("en_hold_op", int'(f_op), 2);
        end
        f_en = 1'b1;
        @(negedge clk);
        chk("en_drain", int'(f_out_valid), 0);
        f_a = 4'b1000; f_in_valid = 1'b1;
        q_a = 4'b0001; q_in_valid = 1'b1;
        @(negedge clk);
        chk("mid_op", int'(f_op), 3);
        chk("mid_q_op", int'(q_op), 0);
        f_in_valid = 1'b0; q_in_valid = 1'b0; rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_valid", int'(f_out_valid), 0);
        chk("mid_rst_q_valid", int'(q_out_valid), 0);
        rst = 1'b0; q_a = 4'b1001; q_in_valid = 1'b1;
        @(negedge clk);
        chk("rr_after_rst_valid", int'(q_out_valid), 1);
        chk("rr_after_rst_op", int'(q_op), 0);
        q_in_valid = 1'b0;

`ifdef SPE_ONEHOT_ERR_EN
        f_in_valid = 1'b1; f_out_ready = 1'b1;
        f_a = 4'b0110;
        @(negedge clk);
        chk("err_op", int'(f_op), 1);
        chk("err_multi", int'(f_err), 1);
        f_a = 4'b0100;
        @(negedge clk);
        chk("err_single", int'(f_err), 0);
        f_a = 4'b0000;
        @(negedge clk);
        chk("err_zero", int'(f_err), 0);
        chk("err_zero_flag", int'(f_zero), 1);
        f_in_valid = 1'b0;
`endif

        // Randomized traffic against the reference model
        mf = '{0, 0, 0, 0, 0};
        mr = '{0, 0, 0, 0, 0};
        rst = 1'b1;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            rst = 1'b0;
            chk("rnd_f_valid", int'(f_out_valid), mf.valid);
            chk("rnd_f_op", int'(f_op), mf.op);
            chk("rnd_f_zero", int'(f_zero), mf.zero);
            chk("rnd_r_valid", int'(r_out_valid), mr.valid);
            chk("rnd_r_op", int'(r_op), mr.op);
            chk("rnd_r_zero", int'(r_zero), mr.zero);
`ifdef SPE_ONEHOT_ERR_EN
            chk("rnd_f_err", int'(f_err), mf.err);
            chk("rnd_r_err", int'(r_err), mr.err);
`endif
            f_en = ($urandom_range(0, 7) != 0);
            f_in_valid = 1'($urandom_range(0, 1));
            f_out_ready = ($urandom_range(0, 3) != 0);
            f_a = 4'($urandom_range(0, 15));
            r_en = ($urandom_range(0, 7) != 0);
            r_in_valid = 1'($urandom_range(0, 1));
            r_out_ready = ($urandom_range(0, 3) != 0);
            r_a = 5'($urandom_range(0, 31));
            #1;
            chk("rnd_f_in_ready", int'(f_in_ready),
                (f_en && (mf.valid == 0 || f_out_ready)) ? 1 : 0);
            chk("rnd_r_in_ready", int'(r_in_ready),
                (r_en && (mr.valid == 0 || r_out_ready)) ? 1 : 0);
            mf = mdl_step(mf, 4, 0, int'(f_en), int'(f_in_valid), int'(f_a), int'(f_out_ready));
            mr = mdl_step(mr, 5, 1, int'(r_en), int'(r_in_valid), int'(r_a), int'(r_out_ready));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/stream_priority_encoder.md
Name: stream_priority_encoder

Overview:
- Registered, handshaked successor to the combinational encoder.
- Accepts an IP_WIDTH-bit request vector over valid/ready and returns the encoded index one cycle later on a valid/ready output.
- Supports fixed-priority mode and round-robin mode (rotating pointer).
- Sits between request-gathering logic and the arbitration/dispatch stages of a pipeline.

Parameters:
- IP_WIDTH, 4, request vector width; legal range 2..64; need not be a power of two.
- RR_MODE, 0, 0 = fixed priority (lowest index wins); 1 = round-robin starting at the rotating pointer.
- OP_SIZE, $clog2(IP_WIDTH), localparam; encoded output width.

Ports:
- clk  in  1  single clock; all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- en  in  1  block enable; 0 = no accept, all state frozen.
- a  in  IP_WIDTH  request vector.
- in_valid  in  1  a is valid this cycle.
- in_ready  out  1  block can accept a this cycle.
- op  out  OP_SIZE  encoded winning index.
- zero  out  1  accepted vector was all zeros (op forced to 0).
- out_valid  out  1  op/zero hold a result.
- out_ready  in  1  consumer takes the result this cycle.

Behaviour:
- Reset (synchronous, rst=1 at a clk edge): out_valid=0, op=0, zero=0, rr pointer ptr=0; err=0 if the optional feature is compiled in. rst has priority over en and all handshakes.
- in_ready = en && (!out_valid || out_ready). This is combinational from out_ready and en. No path from in_valid to in_ready.
- Accept occurs when in_valid && in_ready at a clk edge. On that edge:
  - out_valid<=1.
  - op<=winner.
  - zero<=(a==0).
- Latency: 1 cycle from accept to out_valid. Throughput: one result per cycle while out_ready=1.
- Output holds stable while out_valid && !out_ready (backpressure). a is not sampled in this state.
- Drain without a new accept (out_valid && out_ready && !(in_valid && in_ready)): out_valid<=0; op and zero keep their last values.
- Simultaneous drain and accept: the new result replaces the old in the same edge; out_valid stays 1.
- Fixed mode (RR_MODE=0): winner = lowest set index of a.
- Round-robin mode (RR_MODE=1):
  - Winner = first set bit scanning indices ptr, ptr+1, …, IP_WIDTH-1, 0, …, ptr-1.
  - On an accept with a!=0: ptr <= (winner+1) mod IP_WIDTH.
  - Wrap uses IP_WIDTH, not 2**OP_SIZE. For IP_WIDTH=5, winner 4 gives ptr=0.
- All-zero input: op<=0, zero<=1, ptr unchanged.
- ptr is internal and advances only on accept; it is frozen when en=0.
- en=0 mid-transaction:
  - in_ready=0; no accept.
  - out_valid/op/zero hold even if out_ready=1. The result is not drained until en returns to 1.
- Reset mid-transaction discards any pending result (out_valid=0 next cycle) and returns ptr to 0.
- Outputs are registered except in_ready.

Optional Feature:
- Macro: SPE_ONEHOT_ERR_EN.
- Defined:
  - Adds output port err (out, 1).
  - On accept, err<=1 if popcount(a)>1, else 0. err is registered alongside op and held under backpressure.
  - Reset value 0.
  - Encoding result is unaffected.
  - Used to flag non-one-hot requests when the block acts as a plain encoder.
- Undefined: no err port, no popcount logic; behaviour otherwise identical.

Test Plan:
- Reset check, IP_WIDTH=4: hold rst=1 for 2 cycles with in_valid=1, a=4'b1000 → out_valid=0, op=0, zero=0 throughout; first accept after release (a=4'b1000, out_ready=1) → op=3, out_valid=1 next cycle.
- Fixed mode, IP_WIDTH=4, out_ready=1, one accept per cycle of a=4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b1010, 4'b0000 → op sequence 0,1,2,3,1,0; zero=1 only on the last; one result per cycle.
- Round-robin wrap, IP_WIDTH=5, RR_MODE=1, a=5'b10101 held for 4 accepts → op=0,2,4,0. Then a=5'b00000 → zero=1, op=0, and the next a=5'b00010 gives op=1 (ptr unchanged by the zero vector).
- Backpressure: out_ready=0 for 3 cycles after accepting a=4'b0100 → op=2 and out_valid=1 stable, in_ready=0, new a ignored. Then out_ready=1 with in_valid=1, a=4'b0001 → op=0 the following cycle, no bubble.
- Enable and reset mid-flight: with out_valid=1 (op=2) set en=0 and out_ready=1 for 2 cycles → in_ready=0, result held. en=1 → result drains. Then accept a=4'b1000 and assert rst the cycle after → out_valid=0; in RR mode the next accept of a=4'b1001 gives op=0.
- SPE_ONEHOT_ERR_EN defined: accept a=4'b0110 → op=1, err=1; accept a=4'b0100 → err=0; accept a=4'b0000 → err=0, zero=1.
